// File: rtl/dec_pkg.sv
// Shared state type and select-line helpers for the dec_scan_n decoder family.
package dec_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_BLANK = 2'd2
  } scan_state_t;

  // Widest decoder supported by the helpers; callers cast down to their own width.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;

  function automatic int out_w(input int sel_w);
    return 1 << sel_w;
  endfunction

  function automatic logic [MAX_OUT_W-1:0] idle_lines(input logic active_low);
    return active_low ? {MAX_OUT_W{1'b1}} : {MAX_OUT_W{1'b0}};
  endfunction

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                                  input logic active_low);
    logic [MAX_OUT_W-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return active_low ? ~r : r;
  endfunction

endpackage

// File: rtl/dec_scan_n_tick_div.sv
// Prescaler counting 0..DIV-1 with synchronous clear; flags the terminal count
// and the count just before it so callers can register look-ahead strobes.
module tick_div #(
  parameter int DIV = 1000,
  parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc,
  output logic o_pre_tc
);

  localparam logic [CW-1:0] TC_VAL  = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE_VAL = CW'((DIV >= 2) ? DIV - 2 : 0);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == TC_VAL) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tc     = (r_cnt == TC_VAL);
  assign o_pre_tc = (r_cnt == PRE_VAL);

endmodule

// File: rtl/dec_scan_n.sv
// Registered 74HC138-style decoder with direct decode and a blanked auto-scan mode.
// Every output is computed from next-state values and registered, so y never glitches.
module dec_scan_n
  import dec_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DIV        = 1000,
  parameter int BLANK      = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      e1_n,
  input  logic                      e2_n,
  input  logic                      e3,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [SEL_W-1:0]          last,
  output logic [(1 << SEL_W)-1:0]   y,
  output logic [SEL_W-1:0]          idx,
  output logic                      slot_stb,
  output logic                      frame_stb
);

  localparam int OUT_W = out_w(SEL_W);
  localparam int BW    = (BLANK > 0) ? (($clog2(BLANK + 1) > 1) ? $clog2(BLANK + 1) : 1) : 1;
  localparam logic             AL         = (ACTIVE_LOW != 0);
  localparam logic [OUT_W-1:0] IDLE_Y     = OUT_W'(idle_lines(AL));
  localparam logic [BW-1:0]    BLANK_LAST = BW'((BLANK > 0) ? BLANK - 1 : 0);

  scan_state_t      r_state, w_state_nx;
  logic [BW-1:0]    r_bcnt, w_bcnt_nx;
  logic [SEL_W-1:0] r_idx, w_idx_nx;
  logic [OUT_W-1:0] r_y, w_y_nx;
  logic             r_slot, r_frame;
  logic             w_en, w_direct, w_run, w_adv, w_wrap, w_tc, w_pre_tc;

  assign w_en     = e3 & ~e1_n & ~e2_n;
  assign w_direct = w_en & ~mode;

  tick_div #(.DIV(DIV)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (~w_run),
    .i_en     (w_run),
    .o_tc     (w_tc),
    .o_pre_tc (w_pre_tc)
  );

  // Abort (en low or mode low) beats everything; otherwise step the scan FSM.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_bcnt_nx  = r_bcnt;
    w_run      = 1'b0;
    w_adv      = 1'b0;
    if (!(w_en && mode)) begin
      w_state_nx = S_IDLE;
      if (w_direct) w_idx_nx = sel;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nx = S_DRIVE;
          w_idx_nx   = '0;
        end
        S_DRIVE: begin
          w_run = 1'b1;
          if (w_tc) begin
            if (BLANK > 0) begin
              w_state_nx = S_BLANK;
              w_bcnt_nx  = '0;
            end else begin
              w_adv = 1'b1;
            end
          end
        end
        S_BLANK: begin
          if (r_bcnt == BLANK_LAST) begin
            w_adv      = 1'b1;
            w_state_nx = S_DRIVE;
          end else begin
            w_bcnt_nx = r_bcnt + 1'b1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
    w_wrap = w_adv && (r_idx >= last);
    if (w_adv) w_idx_nx = w_wrap ? '0 : r_idx + 1'b1;
    if (w_state_nx == S_DRIVE) begin
      w_y_nx = OUT_W'(onehot(MAX_SEL_W'(w_idx_nx), AL));
    end else if (w_direct) begin
      w_y_nx = OUT_W'(onehot(MAX_SEL_W'(sel), AL));
    end else begin
      w_y_nx = IDLE_Y;
    end
  end

  // slot_stb is registered one clock early so it lands on the final drive clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_idx   <= '0;
      r_y     <= IDLE_Y;
      r_slot  <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_bcnt  <= w_bcnt_nx;
      r_idx   <= w_idx_nx;
      r_y     <= w_y_nx;
      r_slot  <= w_run & w_pre_tc;
      r_frame <= w_wrap;
    end
  end

  assign y         = r_y;
  assign idx       = r_idx;
  assign slot_stb  = r_slot;
  assign frame_stb = r_frame;

endmodule

// File: tb/tb_dec_scan_n.sv
// Self-checking bench for dec_scan_n: one DUT with BLANK=1, one with BLANK=0, shared inputs.
module tb_dec_scan_n;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       e1_n = 1'b1, e2_n = 1'b1, e3 = 1'b0, mode = 1'b0;
  logic [2:0] sel = 3'd0, last = 3'd7;
  logic [7:0] y1, y0;
  logic [2:0] idx1, idx0;
  logic       slot1, slot0, frame1, frame0;

  int checks = 0;
  int errors = 0;

  // Scan reference: position inside the current slot, slot index, pending frame pulse.
  int m_t, m_idx;
  bit m_frame;

  always #5 clk = ~clk;

  dec_scan_n #(.SEL_W(3), .DIV(DIV), .BLANK(1), .ACTIVE_LOW(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .e1_n(e1_n), .e2_n(e2_n), .e3(e3), .mode(mode),
    .sel(sel), .last(last), .y(y1), .idx(idx1), .slot_stb(slot1), .frame_stb(frame1)
  );

  dec_scan_n #(.SEL_W(3), .DIV(DIV), .BLANK(0), .ACTIVE_LOW(1)) dut_b0 (
    .clk(clk), .rst_n(rst_n), .e1_n(e1_n), .e2_n(e2_n), .e3(e3), .mode(mode),
    .sel(sel), .last(last), .y(y0), .idx(idx0), .slot_stb(slot0), .frame_stb(frame0)
  );

  function automatic logic [7:0] lines(input int i);
    return 8'hFF ^ (8'h01 << i);
  endfunction

  task automatic go_idle();
    mode = 1'b0;
    e3   = 1'b0;
    @(negedge clk);
  endtask

  task automatic enable_scan(input logic [2:0] l);
    e1_n = 1'b0;
    e2_n = 1'b0;
    e3   = 1'b1;
    mode = 1'b1;
    last = l;
  endtask

  // Advance the slot model at each rising edge, compare the selected DUT at the falling edge.
  task automatic run_scan(input int n, input int blank, input bit fresh, input string tag);
    int         p;
    logic [7:0] ey, oy;
    logic [2:0] oidx;
    logic       os, ofr;
    p = DIV + blank;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      if (fresh && c == 0) begin
        m_t = 0; m_idx = 0; m_frame = 1'b0;
      end else begin
        m_frame = 1'b0;
        m_t++;
        if (m_t == p) begin
          m_t = 0;
          if (m_idx >= int'(last)) begin
            m_idx = 0; m_frame = 1'b1;
          end else begin
            m_idx++;
          end
        end
      end
      @(negedge clk);
      ey = (m_t < DIV) ? lines(m_idx) : 8'hFF;
      if (blank != 0) begin
        oy = y1; oidx = idx1; os = slot1; ofr = frame1;
      end else begin
        oy = y0; oidx = idx0; os = slot0; ofr = frame0;
      end
      checks++;
      if (oy !== ey) begin
        errors++; $display("[TB] FAIL %s_y cyc %0d: got %h want %h", tag, c, oy, ey);
      end
      checks++;
      if (oidx !== 3'(m_idx)) begin
        errors++; $display("[TB] FAIL %s_idx cyc %0d: got %0d want %0d", tag, c, oidx, m_idx);
      end
      checks++;
      if (os !== (m_t == DIV - 1)) begin
        errors++; $display("[TB] FAIL %s_slot cyc %0d: got %b want %b", tag, c, os, (m_t == DIV - 1));
      end
      checks++;
      if (ofr !== m_frame) begin
        errors++; $display("[TB] FAIL %s_frame cyc %0d: got %b want %b", tag, c, ofr, m_frame);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (y1 !== 8'hFF || idx1 !== 3'd0 || slot1 !== 1'b0 || frame1 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_hold: got y=%h idx=%0d want y=ff idx=0", y1, idx1);
    end
    rst_n = 1'b1;
    e1_n = 1'b0; e2_n = 1'b0; e3 = 1'b1; mode = 1'b0; sel = 3'd3;
    @(negedge clk);
    checks++;
    if (y1 !== 8'hF7) begin
      errors++; $display("[TB] FAIL reset_pre_y: got %h want f7", y1);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (y1 !== 8'hFF || y0 !== 8'hFF || idx1 !== 3'd0 || idx0 !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_async: got y1=%h y0=%h idx1=%0d want ff/ff/0", y1, y0, idx1);
    end
    checks++;
    if (slot1 !== 1'b0 || frame1 !== 1'b0 || slot0 !== 1'b0 || frame0 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_strobes: got %b%b%b%b want 0000", slot1, frame1, slot0, frame0);
    end
    @(negedge clk);
    e3 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_direct();
    logic [2:0] exp_idx;
    logic [7:0] exp_y;
    logic       en;
    e1_n = 1'b0; e2_n = 1'b0; e3 = 1'b1; mode = 1'b0; sel = 3'd5;
    @(negedge clk);
    checks++;
    if (y1 !== 8'hDF || idx1 !== 3'd5 || y0 !== 8'hDF) begin
      errors++; $display("[TB] FAIL direct_sel5: got y=%h idx=%0d want df/5", y1, idx1);
    end
    e3 = 1'b0;
    @(negedge clk);
    checks++;
    if (y1 !== 8'hFF || idx1 !== 3'd5) begin
      errors++; $display("[TB] FAIL direct_drop_e3: got y=%h idx=%0d want ff/5", y1, idx1);
    end
    exp_idx = 3'd5;
    for (int k = 0; k < 16; k++) begin
      e1_n = ($urandom_range(0, 3) == 0);
      e2_n = ($urandom_range(0, 3) == 0);
      e3   = ($urandom_range(0, 3) != 0);
      sel  = 3'($urandom_range(0, 7));
      en   = e3 && !e1_n && !e2_n;
      if (en) exp_idx = sel;
      exp_y = en ? lines(int'(sel)) : 8'hFF;
      @(negedge clk);
      checks++;
      if (y1 !== exp_y || y0 !== exp_y) begin
        errors++; $display("[TB] FAIL direct_rand_y %0d: got %h/%h want %h", k, y1, y0, exp_y);
      end
      checks++;
      if (idx1 !== exp_idx || slot1 !== 1'b0 || frame1 !== 1'b0) begin
        errors++; $display("[TB] FAIL direct_rand_idx %0d: got %0d s%b f%b want %0d s0 f0", k, idx1, slot1, frame1, exp_idx);
      end
    end
  endtask

  task automatic test_scan_full();
    go_idle();
    enable_scan(3'd7);
    run_scan(8 * 5 + 6, 1, 1'b1, "scan7");
  endtask

  task automatic test_scan_short();
    int l;
    go_idle();
    enable_scan(3'd2);
    run_scan(3 * 5 + 6, 1, 1'b1, "scan2");
    l = $urandom_range(1, 6);
    go_idle();
    enable_scan(3'(l));
    run_scan((l + 1) * 5 + 3, 1, 1'b1, "scanr");
  endtask

  task automatic test_last_change();
    int guard = 0;
    go_idle();
    enable_scan(3'd7);
    run_scan(1, 1, 1'b1, "lastchg");
    while (!(m_idx == 5 && m_t == 1) && guard < 100) begin
      run_scan(1, 1, 1'b0, "lastchg");
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++; $display("[TB] FAIL lastchg_reach: got idx %0d want 5 within budget", m_idx);
    end
    last = 3'd2;
    run_scan(20, 1, 1'b0, "lastchg2");
  endtask

  task automatic test_abort();
    int guard = 0;
    int at_idx, at_t;
    at_idx = $urandom_range(1, 6);
    at_t   = $urandom_range(0, DIV - 2);
    go_idle();
    enable_scan(3'd7);
    run_scan(1, 1, 1'b1, "abort");
    while (!(m_idx == at_idx && m_t == at_t) && guard < 100) begin
      run_scan(1, 1, 1'b0, "abort");
      guard++;
    end
    e2_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (y1 !== 8'hFF || idx1 !== 3'(at_idx)) begin
        errors++; $display("[TB] FAIL abort_y %0d: got y=%h idx=%0d want ff/%0d", k, y1, idx1, at_idx);
      end
      checks++;
      if (slot1 !== 1'b0 || frame1 !== 1'b0) begin
        errors++; $display("[TB] FAIL abort_strobes %0d: got s%b f%b want s0 f0", k, slot1, frame1);
      end
    end
    e2_n = 1'b0;
    run_scan(7, 1, 1'b1, "reentry");
    mode = 1'b0;
    sel  = 3'd6;
    @(negedge clk);
    checks++;
    if (y1 !== 8'hBF || idx1 !== 3'd6 || slot1 !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_to_direct: got y=%h idx=%0d want bf/6", y1, idx1);
    end
  endtask

  task automatic test_blank0();
    go_idle();
    enable_scan(3'd7);
    run_scan(8 * 4 + 5, 0, 1'b1, "nob");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (y0 !== 8'hFF || idx0 !== 3'd0 || slot0 !== 1'b0 || frame0 !== 1'b0) begin
      errors++; $display("[TB] FAIL nob_async_reset: got y=%h idx=%0d want ff/0", y0, idx0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(9, 0, 1'b1, "nob_restart");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_direct();
    test_scan_full();
    test_scan_short();
    test_last_change();
    test_abort();
    test_blank0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
